// File: rtl/player_input_controller.sv
// player_input_controller
// Chooses between vision and pushbutton control, keeps the player lane moving
// one step at a time toward a target lane, and issues rate-limited jump pulses.
// Everything runs in the 65 MHz system clock domain.

module player_input_controller #(
    parameter logic [29:0] LANE_STEP_CYCLES = 30'd6_500_000,
    parameter logic [29:0] VISION_TIMEOUT   = 30'd65_000_000,
    parameter logic [29:0] JUMP_COOLDOWN    = 30'd32_500_000
) (
    input  logic       system_clock_in,
    input  logic       system_reset_n,
    input  logic [1:0] vision_lane,
    input  logic       vision_jump,
    input  logic       vision_valid,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       force_buttons,
    input  logic       game_active,
    output logic [1:0] player_lane,
    output logic       jump_pulse,
    output logic       source_vision,
    output logic       vision_lost
);

    typedef enum logic {
        SRC_BUTTONS = 1'b0,
        SRC_VISION  = 1'b1
    } srcState_t;

    typedef enum logic {
        STEP_IDLE = 1'b0,
        STEP_WAIT = 1'b1
    } stepState_t;

    srcState_t  r_srcState;
    stepState_t r_stepState;

    logic [29:0] r_watchdog;
    logic [29:0] r_stepTimer;
    logic [29:0] r_cooldown;
    logic [1:0]  r_target;
    logic [1:0]  r_playerLane;
    logic        r_jumpPulse;
    logic        r_sourceVision;
    logic        r_visionLost;
    logic        r_visionJumpPrev;
    logic        r_btnJumpPrev;

    logic        w_visionJumpReq;
    logic        w_btnJumpReq;
    logic        w_jumpReq;
    logic        w_timeoutHit;
    logic        w_enterButtons;
    logic [1:0]  w_targetNext;

    assign player_lane   = r_playerLane;
    assign jump_pulse    = r_jumpPulse;
    assign source_vision = r_sourceVision;
    assign vision_lost   = r_visionLost;

    // A jump request is a rising edge on whichever source currently has control.
    assign w_visionJumpReq = vision_jump & ~r_visionJumpPrev;
    assign w_btnJumpReq    = btn_jump & ~r_btnJumpPrev;
    assign w_jumpReq       = (r_srcState == SRC_VISION) ? w_visionJumpReq : w_btnJumpReq;

    // Vision has been silent for the full timeout once this cycle is also silent.
    assign w_timeoutHit   = (r_srcState == SRC_VISION) && !force_buttons && !vision_valid &&
                            (r_watchdog == VISION_TIMEOUT - 30'd1);
    assign w_enterButtons = (r_srcState == SRC_VISION) && (force_buttons || w_timeoutHit);

    // Source selection: vision takes over whenever it is valid and not overridden,
    // and gives control back on override or after a long silence.
    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_srcState     <= SRC_BUTTONS;
            r_watchdog     <= 30'd0;
            r_sourceVision <= 1'b0;
            r_visionLost   <= 1'b1;
        end else begin
            case (r_srcState)
                SRC_BUTTONS: begin
                    if (vision_valid && !force_buttons) begin
                        r_srcState     <= SRC_VISION;
                        r_watchdog     <= 30'd0;
                        r_sourceVision <= 1'b1;
                        r_visionLost   <= 1'b0;
                    end
                end
                SRC_VISION: begin
                    if (force_buttons) begin
                        r_srcState     <= SRC_BUTTONS;
                        r_watchdog     <= 30'd0;
                        r_sourceVision <= 1'b0;
                    end else if (vision_valid) begin
                        r_watchdog <= 30'd0;
                    end else if (w_timeoutHit) begin
                        r_srcState     <= SRC_BUTTONS;
                        r_watchdog     <= 30'd0;
                        r_sourceVision <= 1'b0;
                        r_visionLost   <= 1'b1;
                    end else begin
                        r_watchdog <= r_watchdog + 30'd1;
                    end
                end
                default: begin
                    r_srcState     <= SRC_BUTTONS;
                    r_watchdog     <= 30'd0;
                    r_sourceVision <= 1'b0;
                    r_visionLost   <= 1'b1;
                end
            endcase
        end
    end

    // Previous jump levels; a jump already held when vision takes over is not an edge.
    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_visionJumpPrev <= 1'b0;
            r_btnJumpPrev    <= 1'b0;
        end else begin
            r_visionJumpPrev <= vision_jump;
            r_btnJumpPrev    <= btn_jump;
        end
    end

    // Next target lane: vision sets it directly, buttons nudge it with saturation.
    always_comb begin
        w_targetNext = r_target;
        if (!game_active) begin
            w_targetNext = 2'd1;
        end else if (w_enterButtons) begin
            w_targetNext = r_playerLane;
        end else if (r_srcState == SRC_VISION) begin
            if (vision_valid && (vision_lane != 2'd3)) begin
                w_targetNext = vision_lane;
            end
        end else begin
            if (btn_left && !btn_right && (r_target != 2'd0)) begin
                w_targetNext = r_target - 2'd1;
            end else if (btn_right && !btn_left && (r_target != 2'd2)) begin
                w_targetNext = r_target + 2'd1;
            end
        end
    end

    // Target lane register.
    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_target <= 2'd1;
        end else begin
            r_target <= w_targetNext;
        end
    end

    // Lane stepper: one lane per step interval toward the target.
    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_stepState  <= STEP_IDLE;
            r_stepTimer  <= 30'd0;
            r_playerLane <= 2'd1;
        end else if (!game_active) begin
            r_stepState  <= STEP_IDLE;
            r_stepTimer  <= 30'd0;
            r_playerLane <= 2'd1;
        end else begin
            case (r_stepState)
                STEP_IDLE: begin
                    if (r_target != r_playerLane) begin
                        if (r_target > r_playerLane) begin
                            r_playerLane <= r_playerLane + 2'd1;
                        end else begin
                            r_playerLane <= r_playerLane - 2'd1;
                        end
                        if (LANE_STEP_CYCLES > 30'd1) begin
                            r_stepTimer <= LANE_STEP_CYCLES - 30'd1;
                            r_stepState <= STEP_WAIT;
                        end
                    end
                end
                STEP_WAIT: begin
                    if (r_stepTimer <= 30'd1) begin
                        r_stepTimer <= 30'd0;
                        r_stepState <= STEP_IDLE;
                    end else begin
                        r_stepTimer <= r_stepTimer - 30'd1;
                    end
                end
                default: begin
                    r_stepTimer <= 30'd0;
                    r_stepState <= STEP_IDLE;
                end
            endcase
        end
    end

    // Jump issue with cooldown; requests during cooldown are simply dropped.
    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_jumpPulse <= 1'b0;
            r_cooldown  <= 30'd0;
        end else if (!game_active) begin
            r_jumpPulse <= 1'b0;
            r_cooldown  <= 30'd0;
        end else if (w_jumpReq && (r_cooldown == 30'd0)) begin
            r_jumpPulse <= 1'b1;
            r_cooldown  <= JUMP_COOLDOWN;
        end else begin
            r_jumpPulse <= 1'b0;
            if (r_cooldown != 30'd0) begin
                r_cooldown <= r_cooldown - 30'd1;
            end
        end
    end

endmodule

// File: tb/tb_player_input_controller.sv
// tb_player_input_controller
// Scoreboard bench: the driver applies stimulus and a timestamp-based reference
// model pushes the expected outputs; a monitor pops and compares on every negedge.

module tb_player_input_controller;

    localparam int LSC = 4;
    localparam int VT  = 16;
    localparam int JC  = 8;

    logic       clock;
    logic       resetN;
    logic [1:0] vision_lane;
    logic       vision_jump;
    logic       vision_valid;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic       force_buttons;
    logic       game_active;
    logic [1:0] player_lane;
    logic       jump_pulse;
    logic       source_vision;
    logic       vision_lost;

    int checks = 0;
    int errors = 0;
    int observedPulses = 0;

    typedef struct {
        int lane;
        int jump;
        int srcv;
        int lost;
        int cycle;
    } expect_t;

    expect_t sbQueue[$];

    // Reference model state: source mode, silence length and event timestamps.
    bit mVision;
    bit mLost;
    int mSilent;
    int mTarget;
    int mLane;
    int mLastStep;
    int mLastJump;
    bit mPrevVj;
    bit mPrevBj;
    int mCycle;
    int mJump;

    player_input_controller #(
        .LANE_STEP_CYCLES(30'(LSC)),
        .VISION_TIMEOUT  (30'(VT)),
        .JUMP_COOLDOWN   (30'(JC))
    ) dut (
        .system_clock_in(clock),
        .system_reset_n (resetN),
        .vision_lane    (vision_lane),
        .vision_jump    (vision_jump),
        .vision_valid   (vision_valid),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_jump       (btn_jump),
        .force_buttons  (force_buttons),
        .game_active    (game_active),
        .player_lane    (player_lane),
        .jump_pulse     (jump_pulse),
        .source_vision  (source_vision),
        .vision_lost    (vision_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, wanted %0d", name, mCycle, actual, expected);
        end
    endtask

    task automatic modelReset();
        mVision   = 1'b0;
        mLost     = 1'b1;
        mSilent   = 0;
        mTarget   = 1;
        mLane     = 1;
        mLastStep = -1000;
        mLastJump = -1000;
        mPrevVj   = 1'b0;
        mPrevBj   = 1'b0;
        mJump     = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic modelEdge();
        int  oldLane;
        int  oldTarget;
        bit  oldVision;
        bit  req;
        bit  leaving;
        oldLane   = mLane;
        oldTarget = mTarget;
        oldVision = mVision;
        leaving   = 1'b0;
        mCycle++;

        req = oldVision ? (vision_jump && !mPrevVj) : (btn_jump && !mPrevBj);
        mPrevVj = vision_jump;
        mPrevBj = btn_jump;

        if (!oldVision) begin
            if (vision_valid && !force_buttons) begin
                mVision = 1'b1;
                mLost   = 1'b0;
                mSilent = 0;
            end
        end else if (force_buttons) begin
            mVision = 1'b0;
            leaving = 1'b1;
        end else if (vision_valid) begin
            mSilent = 0;
        end else begin
            mSilent++;
            if (mSilent == VT) begin
                mVision = 1'b0;
                mLost   = 1'b1;
                mSilent = 0;
                leaving = 1'b1;
            end
        end

        if (!game_active) begin
            mJump     = 0;
            mLastJump = -1000;
        end else if (req && (mCycle - mLastJump > JC)) begin
            mJump     = 1;
            mLastJump = mCycle;
        end else begin
            mJump = 0;
        end

        if (!game_active) begin
            mLane     = 1;
            mTarget   = 1;
            mLastStep = -1000;
        end else begin
            if ((oldTarget != oldLane) && (mCycle - mLastStep >= LSC)) begin
                mLane     = (oldTarget > oldLane) ? oldLane + 1 : oldLane - 1;
                mLastStep = mCycle;
            end
            if (leaving) begin
                mTarget = oldLane;
            end else if (oldVision) begin
                if (vision_valid && (vision_lane != 2'd3)) mTarget = int'(vision_lane);
            end else begin
                if (btn_left && !btn_right && oldTarget > 0) mTarget = oldTarget - 1;
                else if (btn_right && !btn_left && oldTarget < 2) mTarget = oldTarget + 1;
            end
        end
    endtask

    // One clock of stimulus with the given button pulses; levels are set by the caller.
    task automatic applyStimulus(input bit bl, input bit br, input bit bj);
        expect_t e;
        btn_left  = bl;
        btn_right = br;
        btn_jump  = bj;
        @(posedge clock);
        modelEdge();
        e.lane  = mLane;
        e.jump  = mJump;
        e.srcv  = int'(mVision);
        e.lost  = int'(mLost);
        e.cycle = mCycle;
        sbQueue.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented output sample against the scoreboard head.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (jump_pulse) observedPulses++;
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("player_lane", int'(player_lane), e.lane);
                checkOutput("jump_pulse", int'(jump_pulse), e.jump);
                checkOutput("source_vision", int'(source_vision), e.srcv);
                checkOutput("vision_lost", int'(vision_lost), e.lost);
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        int snap;
        mCycle        = 0;
        resetN        = 1'b0;
        vision_lane   = 2'd1;
        vision_jump   = 1'b0;
        vision_valid  = 1'b0;
        btn_left      = 1'b0;
        btn_right     = 1'b0;
        btn_jump      = 1'b0;
        force_buttons = 1'b0;
        game_active   = 1'b1;
        modelReset();
        #23;
        checkOutput("reset_lane", int'(player_lane), 1);
        checkOutput("reset_jump", int'(jump_pulse), 0);
        checkOutput("reset_source", int'(source_vision), 0);
        checkOutput("reset_lost", int'(vision_lost), 1);
        @(negedge clock);
        #1 resetN = 1'b1;

        // Button mode: step right, then saturate at lane 2.
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(2);
        checkOutput("btn_right_lane", int'(player_lane), 2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle(6);
        checkOutput("btn_right_saturate", int'(player_lane), 2);

        // Vision takes over and walks the lane from 2 down to 0; lane 3 is ignored.
        vision_lane  = 2'd0;
        vision_valid = 1'b1;
        idle(12);
        checkOutput("vision_lane0", int'(player_lane), 0);
        vision_lane = 2'd3;
        idle(6);
        checkOutput("vision_lane3_ignored", int'(player_lane), 0);

        // Watchdog: 15 silent cycles survive, 16 fall back to buttons.
        vision_valid = 1'b0;
        idle(15);
        vision_valid = 1'b1;
        idle(2);
        checkOutput("silence15_source", int'(source_vision), 1);
        vision_valid = 1'b0;
        idle(16);
        checkOutput("timeout_source", int'(source_vision), 0);
        checkOutput("timeout_lost", int'(vision_lost), 1);
        idle(4);

        // Jump edges and cooldown under vision control.
        snap        = observedPulses;
        vision_jump = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        vision_valid = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        idle(3);
        vision_jump = 1'b0;
        idle(1);
        vision_jump = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        vision_jump = 1'b0;
        idle(2);
        vision_jump = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        vision_jump = 1'b0;
        idle(8);
        vision_jump = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        vision_jump = 1'b0;
        idle(2);
        checkOutput("jump_pulse_count", observedPulses - snap, 2);

        // Back to buttons, both directions at once, then a frozen game.
        vision_valid = 1'b0;
        idle(17);
        applyStimulus(1'b1, 1'b1, 1'b0);
        idle(6);
        checkOutput("both_buttons_lane", int'(player_lane), 0);
        snap        = observedPulses;
        game_active = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);
        checkOutput("inactive_lane", int'(player_lane), 1);
        checkOutput("inactive_jumps", observedPulses - snap, 0);
        game_active = 1'b1;
        idle(2);

        // Reset in the middle of a lane wait with cooldown running.
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1 resetN = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset_lane", int'(player_lane), 1);
        checkOutput("midreset_jump", int'(jump_pulse), 0);
        checkOutput("midreset_source", int'(source_vision), 0);
        checkOutput("midreset_lost", int'(vision_lost), 1);
        #20;
        @(negedge clock);
        #1 resetN = 1'b1;
        snap = observedPulses;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_jump", observedPulses - snap, 1);
        idle(4);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) vision_valid = ~vision_valid;
            if ($urandom_range(0, 3) == 0) vision_lane = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) vision_jump = ~vision_jump;
            if ($urandom_range(0, 59) == 0) force_buttons = ~force_buttons;
            if ($urandom_range(0, 79) == 0) game_active = ~game_active;
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 9) == 0);
        end
        idle(2);
        @(negedge clock);
        #1;
        checkOutput("scoreboard_drained", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
